fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ==========================================================================
// fetch_unit -- single-outstanding instruction fetcher, 2-entry buffer, redirect
// Rev 1.0
// ==========================================================================
`default_nettype none

module fetch_unit #(
  parameter int          PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  output logic [15:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                instr_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state_q;
  logic                imem_req_q;
  logic [PC_WIDTH-1:0] imem_addr_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [1:0]          count_q, count_d;
  logic [15:0]         instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic                pop;
  logic                push;
  logic                issue;
  logic [1:0]          cnt_after_pop;

  assign instr_valid   = (count_q != 2'd0);
  assign instr         = instr0_q;
  assign instr_pc      = pc0_q;
  assign imem_req      = imem_req_q;
  assign imem_addr     = imem_addr_q;

  assign pop           = instr_valid && instr_ready;
  assign push          = (state_q == S_WAIT) && imem_ack && !redirect_valid;
  assign cnt_after_pop = count_q - {1'b0, pop};
  // Issue only when the slot the request will fill is guaranteed free on return.
  assign issue         = (state_q == S_IDLE) && (cnt_after_pop < 2'd2) && !redirect_valid;

  // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
  always_comb begin
    count_d  = count_q;
    instr0_d = instr0_q;
    pc0_d    = pc0_q;
    instr1_d = instr1_q;
    pc1_d    = pc1_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        instr0_d = instr1_q;
        pc0_d    = pc1_q;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          instr0_d = imem_rdata;
          pc0_d    = imem_addr_q;
        end else begin
          instr1_d = imem_rdata;
          pc1_d    = imem_addr_q;
        end
        count_d = cnt_after_pop + 2'd1;
      end else begin
        count_d = cnt_after_pop;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      fetch_pc_q  <= PC_WIDTH'(RESET_PC);
      count_q     <= 2'd0;
      instr0_q    <= '0;
      pc0_q       <= '0;
      instr1_q    <= '0;
      pc1_q       <= '0;
    end else begin
      count_q  <= count_d;
      instr0_q <= instr0_d;
      pc0_q    <= pc0_d;
      instr1_q <= instr1_d;
      pc1_q    <= pc1_d;

      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + PC_WIDTH'(1);
      end

      // A returning ack always closes the request, live or stale.
      if ((state_q != S_IDLE) && imem_ack) begin
        state_q    <= S_IDLE;
        imem_req_q <= 1'b0;
      end else if ((state_q == S_WAIT) && redirect_valid) begin
        state_q <= S_DROP;
      end else if (issue) begin
        state_q     <= S_WAIT;
        imem_req_q  <= 1'b1;
        imem_addr_q <= fetch_pc_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==========================================================================
// tb_fetch_unit -- vector table plus scoreboard bench for fetch_unit
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int           PW    = 8;
  localparam logic [7:0]   RST_A = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [PW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_instr_q[$];
  logic [7:0]  exp_pc_q[$];
  logic        trk, live;
  logic [7:0]  trk_addr, model_pc;

  typedef struct {
    logic       ack;
    logic       rdy;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_pc;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [15:0] mem_data(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, step, update model.
  task automatic cyc(input logic ack, input logic rdy, input logic redir, input logic [7:0] rpc);
    logic ack_eff, pop;
    if (trk) begin
      chk("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, trk_addr);
    end else if (imem_req) begin
      chk("req_addr", imem_addr, model_pc);
      trk = 1'b1;
      live = 1'b1;
      trk_addr = imem_addr;
      model_pc = model_pc + 8'd1;
    end
    chk("valid", instr_valid, exp_pc_q.size() != 0);
    if (instr_valid && exp_pc_q.size() != 0) begin
      chk("instr", instr, exp_instr_q[0]);
      chk("instr_pc", instr_pc, exp_pc_q[0]);
    end
    imem_ack       = ack;
    imem_rdata     = mem_data(imem_addr);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    ack_eff = ack && imem_req;
    pop     = instr_valid && rdy;
    @(posedge clk);
    #1;
    if (redir) begin
      exp_instr_q.delete();
      exp_pc_q.delete();
      model_pc = rpc;
    end else begin
      if (pop && exp_pc_q.size() != 0) begin
        void'(exp_instr_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (ack_eff && live) begin
        exp_instr_q.push_back(mem_data(trk_addr));
        exp_pc_q.push_back(trk_addr);
      end
    end
    if (ack_eff) trk = 1'b0;
    else if (redir) live = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_ack       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", instr_pc, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_instr_q.delete();
    exp_pc_q.delete();
    trk = 1'b0;
    live = 1'b0;
    model_pc = RST_A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03};

    trk = 1'b0; live = 1'b0; trk_addr = '0; model_pc = RST_A;
    @(posedge clk);
    #1;

    // Streaming: immediate acks, always ready
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk("tbl_req", imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
      chk("tbl_valid", instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk("tbl_pc", instr_pc, tbl[i].e_pc);
      cyc(tbl[i].ack, tbl[i].rdy, 1'b0, 8'h00);
    end

    // Decode stalled: buffer fills with 0,1 and fetching stops
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("full_no_req", imem_req, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
    end
    chk("full_valid", instr_valid, 1'b1);
    chk("full_head_pc", instr_pc, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 8'h02);
    chk("resume_head_pc", instr_pc, 8'h01);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Redirect while addr 5 outstanding, ack three cycles later
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 8'd5); i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("drop_setup", {imem_req, imem_addr}, {1'b1, 8'h05});
    cyc(1'b0, 1'b1, 1'b1, 8'h40);
    chk("drop_req_held", imem_req, 1'b1);
    chk("drop_addr_held", imem_addr, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("drop_no_push", instr_valid, 1'b0);
    chk("drop_req_low", imem_req, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drop_new_addr", {imem_req, imem_addr}, {1'b1, 8'h40});
    chk("drop_valid_low", instr_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("drop_ret_pc", {instr_valid, instr_pc}, {1'b1, 8'h40});
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Redirect coincides with ack for addr 3 while one entry buffered
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 8'd3); i++)
      cyc(1'b1, !(instr_valid && instr_pc == 8'd2), 1'b0, 8'h00);
    chk("coin_setup", {imem_req, imem_addr, instr_valid, instr_pc}, {1'b1, 8'h03, 1'b1, 8'h02});
    cyc(1'b1, 1'b1, 1'b1, 8'h10);
    chk("coin_flush", instr_valid, 1'b0);
    chk("coin_req_low", imem_req, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("coin_new_addr", {imem_req, imem_addr}, {1'b1, 8'h10});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Wrap: redirect to all-ones
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("wrap_no_issue", imem_req, 1'b0);
    for (int i = 0; i < 10 && !imem_req; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_addr_ff", {imem_req, imem_addr}, {1'b1, 8'hFF});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("wrap_pc_ff", {instr_valid, instr_pc}, {1'b1, 8'hFF});
    for (int i = 0; i < 10 && !imem_req; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_addr_00", {imem_req, imem_addr}, {1'b1, 8'h00});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Reset mid-request, then a stray ack while imem_req is low
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("mid_setup_req", imem_req, 1'b1);
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("stray_no_push", instr_valid, 1'b0);
    chk("stray_first_req", {imem_req, imem_addr}, {1'b1, RST_A});
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("stray_after_pc", {instr_valid, instr_pc}, {1'b1, RST_A});
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
